// File: rtl/hnf_rxchan_if.sv
// hnf_rxchan_if: CHI RX flit channel plus the show-ahead dequeue port of the
// receive channel. The "slave" side is the receiver itself. The "master" side
// is its surroundings: the link partner drives flits, and the downstream
// consumer drives deq_ready.
interface hnf_rxchan_if #(
   parameter int FLIT_W = 128
);
   logic [FLIT_W-1:0] rx_flit;
   logic              rx_flitv;
   logic              rx_flitpend;
   logic              rx_lcrdv;
   logic [FLIT_W-1:0] deq_data;
   logic              deq_valid;
   logic              deq_ready;

   modport master (
      output rx_flit, rx_flitv, rx_flitpend, deq_ready,
      input  rx_lcrdv, deq_data, deq_valid
   );

   modport slave (
      input  rx_flit, rx_flitv, rx_flitpend, deq_ready,
      output rx_lcrdv, deq_data, deq_valid
   );
endinterface

// File: rtl/hnf_rxchan.sv
// hnf_rxchan: generic CHI link-layer receive channel for the HN-F.
// Receives flits against L-credits, runs the link activate/deactivate
// handshake, flags protocol errors, and buffers flits in a show-ahead queue.
// Optional build macro HNF_RXCHAN_TGTCHK_EN: flits whose TgtID differs from
// HN_ID consume their credit, are discarded and set err_tgtid.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_STOP  | link down, link_ack = 0, no credits granted
// ST_RUN   | link up, link_ack = 1, credits granted up to the limits
// ST_DEACT | tearing down, link_ack = 1, no new credits, wait for all
//          | outstanding credits to come back as flits
module hnf_rxchan #(
   parameter int FLIT_W    = 128,
   parameter int DEPTH     = 8,
   parameter int MAX_LCRD  = 15,
   parameter int TGTID_LSB = 4,
   parameter int TGTID_W   = 7,
   parameter int HN_ID     = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   hnf_rxchan_if.slave            rx,
   input  logic                   link_req,
   output logic                   link_ack,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic [3:0]             credits_out,
   output logic                   err_nocrd,
   output logic                   err_tgtid
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   // Elaboration-time parameter guards.
   if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("hnf_rxchan: DEPTH must be a power of two in 2..64");
   end
   if (MAX_LCRD < 1 || MAX_LCRD > 15) begin : g_bad_lcrd
      $error("hnf_rxchan: MAX_LCRD must be in 1..15");
   end
   if (TGTID_LSB < 0 || TGTID_W < 1 || TGTID_LSB + TGTID_W > FLIT_W) begin : g_bad_tgt
      $error("hnf_rxchan: TgtID field does not fit in the flit");
   end
   if (HN_ID < 0 || HN_ID >= (1 << TGTID_W)) begin : g_bad_hnid
      $error("hnf_rxchan: HN_ID does not fit in TGTID_W bits");
   end

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DEACT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [OCC_W-1:0]  occ_q;
   logic [3:0]        cred_q;
   logic              pend_q;
   logic              lcrdv_q, lcrdv_d;
   logic              err_nocrd_q;
   logic              accept, has_cred, consume, push, pop, tgt_bad;
   logic [7:0]        fill_sum, cred_sum;

   // Accept qualification, credit consumption and queue push/pop decode.
   always_comb begin
      accept   = rx.rx_flitv & pend_q;
      has_cred = (cred_q != 4'd0);
      consume  = accept & has_cred;
      push     = consume & ~tgt_bad;
      pop      = rx.deq_ready & (occ_q != '0);
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_STOP;
      else        state_q <= state_d;
   end

   // Next state, link_ack and credit-grant decision. The grant counts the
   // credit already on the wire (lcrdv_q) so the sender can never hold more
   // credits than free queue slots.
   always_comb begin
      state_d  = state_q;
      link_ack = 1'b0;
      lcrdv_d  = 1'b0;
      fill_sum = 8'(cred_q) + 8'(lcrdv_q) + 8'(occ_q);
      cred_sum = 8'(cred_q) + 8'(lcrdv_q);
      case (state_q)
         ST_STOP: begin
            if (link_req) state_d = ST_RUN;
         end
         ST_RUN: begin
            link_ack = 1'b1;
            lcrdv_d  = (fill_sum < 8'(DEPTH)) && (cred_sum < 8'(MAX_LCRD));
            if (!link_req) state_d = ST_DEACT;
         end
         ST_DEACT: begin
            link_ack = 1'b1;
            // A grant still on the wire counts as outstanding.
            if (cred_q == 4'd0 && !lcrdv_q) state_d = ST_STOP;
         end
         default: state_d = ST_STOP;
      endcase
   end

   // Credit counter, queue pointers/occupancy, pend register, no-credit error.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend_q      <= 1'b0;
         lcrdv_q     <= 1'b0;
         cred_q      <= 4'd0;
         occ_q       <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         err_nocrd_q <= 1'b0;
      end else begin
         pend_q  <= rx.rx_flitpend;
         lcrdv_q <= lcrdv_d;
         cred_q  <= cred_q + 4'(lcrdv_q) - 4'(consume);
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop)      occ_q <= occ_q + OCC_W'(1);
         else if (!push && pop) occ_q <= occ_q - OCC_W'(1);
         if (accept && !has_cred) err_nocrd_q <= 1'b1;
      end
   end

   // Queue storage; contents need no reset because deq_data is masked when empty.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr_q] <= rx.rx_flit;
   end

`ifdef HNF_RXCHAN_TGTCHK_EN
   logic err_tgtid_q;

   assign tgt_bad = (rx.rx_flit[TGTID_LSB +: TGTID_W] != TGTID_W'(HN_ID));

   // Sticky TgtID mismatch flag, set only by credited flits.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                err_tgtid_q <= 1'b0;
      else if (consume && tgt_bad) err_tgtid_q <= 1'b1;
   end

   assign err_tgtid = err_tgtid_q;
`else
   assign tgt_bad   = 1'b0;
   assign err_tgtid = 1'b0;
`endif

   assign rx.rx_lcrdv  = lcrdv_q;
   assign rx.deq_valid = (occ_q != '0);
   assign rx.deq_data  = (occ_q != '0) ? mem[rd_ptr_q] : '0;
   assign occupancy    = occ_q;
   assign credits_out  = cred_q;
   assign err_nocrd    = err_nocrd_q;

endmodule

// File: tb/tb_hnf_rxchan.sv
// tb_hnf_rxchan: directed bench for hnf_rxchan. Two instances: d8 uses the
// default DEPTH=8 and d4 uses DEPTH=4.
module tb_hnf_rxchan;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   hnf_rxchan_if #(.FLIT_W(128)) if8 ();
   hnf_rxchan_if #(.FLIT_W(128)) if4 ();

   logic       link8, link4;
   logic       ack8, ack4;
   logic [3:0] occ8;
   logic [2:0] occ4;
   logic [3:0] cr8, cr4;
   logic       en8, en4, et8, et4;

   hnf_rxchan d8 (
      .clock(clk), .reset(rst_n), .rx(if8), .link_req(link8), .link_ack(ack8),
      .occupancy(occ8), .credits_out(cr8), .err_nocrd(en8), .err_tgtid(et8)
   );

   hnf_rxchan #(.DEPTH(4)) d4 (
      .clock(clk), .reset(rst_n), .rx(if4), .link_req(link4), .link_ack(ack4),
      .occupancy(occ4), .credits_out(cr4), .err_nocrd(en4), .err_tgtid(et4)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int n_lcrd8 = 0;
   int n_lcrd4 = 0;
   int snap;

   // Count high cycles of each credit-grant line.
   always @(negedge clk) begin
      if (if8.rx_lcrdv) n_lcrd8 <= n_lcrd8 + 1;
      if (if4.rx_lcrdv) n_lcrd4 <= n_lcrd4 + 1;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [127:0] mk(input logic [31:0] x);
      return {80'h0, x, 16'h0};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      link8 = 1'b1;
      link4 = 1'b0;
      if8.rx_flit = '0; if8.rx_flitv = 1'b0; if8.rx_flitpend = 1'b0; if8.deq_ready = 1'b0;
      if4.rx_flit = '0; if4.rx_flitv = 1'b0; if4.rx_flitpend = 1'b0; if4.deq_ready = 1'b0;

      // ---------------- reset state ----------------
      tick(3);
      chk("rst_lcrdv", 128'(if8.rx_lcrdv), 0);
      chk("rst_ack",   128'(ack8), 0);
      chk("rst_dvalid", 128'(if8.deq_valid), 0);
      chk("rst_occ",   128'(occ8), 0);
      chk("rst_cred",  128'(cr8), 0);
      chk("rst_errs",  128'({en8, et8, en4, et4}), 0);
      chk("rst_ddata", if8.deq_data, 0);

      // ---------------- link-up on d8 ----------------
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("up_ack",        128'(ack8), 1);
      chk("up_lcrdv_n1",   128'(if8.rx_lcrdv), 0);
      tick();
      chk("up_lcrdv_n2",   128'(if8.rx_lcrdv), 1);
      tick(11);
      chk("up_lcrd_count", 128'(n_lcrd8), 8);
      chk("up_cred",       128'(cr8), 8);
      chk("up_occ",        128'(occ8), 0);

      // ---------------- TgtID = 3 flit on d8 ----------------
      if8.rx_flitpend = 1'b1;
      tick();
      if8.rx_flitv = 1'b1; if8.rx_flit = 128'h30; if8.rx_flitpend = 1'b0;
      tick();
      if8.rx_flitv = 1'b0;
      chk("tgt_cred", 128'(cr8), 7);
      chk("tgt_nocrd", 128'(en8), 0);
`ifdef HNF_RXCHAN_TGTCHK_EN
      chk("tgt_occ",  128'(occ8), 0);
      chk("tgt_err",  128'(et8), 1);
`else
      chk("tgt_occ",  128'(occ8), 1);
      chk("tgt_err",  128'(et8), 0);
      chk("tgt_data", if8.deq_data, 128'h30);
      if8.deq_ready = 1'b1;
      tick();
      if8.deq_ready = 1'b0;
`endif
      tick(6);
      chk("tgt_refill", 128'(cr8), 8);

      // ---------------- d8 stream 4 flits then drain ----------------
      if8.rx_flitpend = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         if8.rx_flitv = 1'b1; if8.rx_flit = mk(32'h1000 + 32'(i)); if8.rx_flitpend = (i < 3);
         tick();
      end
      if8.rx_flitv = 1'b0;
      chk("str_occ",  128'(occ8), 4);
      chk("str_cred", 128'(cr8), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("str_order%0d", i), if8.deq_data, mk(32'h1000 + 32'(i)));
         if8.deq_ready = 1'b1;
         tick();
      end
      if8.deq_ready = 1'b0;
      chk("str_empty", 128'(if8.deq_valid), 0);
      tick(10);
      chk("str_refill", 128'(cr8), 8);

      // ---------------- simultaneous push/pop/credit on d8 ----------------
      if8.rx_flitpend = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         if8.rx_flitv = 1'b1; if8.rx_flit = mk(32'h2000 + 32'(i));
         tick();
      end
      if8.rx_flitv = 1'b0;
      chk("sim_occ3", 128'(occ8), 3);
      chk("sim_cr5",  128'(cr8), 5);
      if8.deq_ready = 1'b1;
      tick();
      chk("sim_pop_occ", 128'(occ8), 2);
      chk("sim_pop_cr",  128'(cr8), 5);
      if8.deq_ready = 1'b0;
      if8.rx_flitv = 1'b1; if8.rx_flit = mk(32'h3000);
      tick();
      chk("sim_pre_occ",   128'(occ8), 3);
      chk("sim_pre_cr",    128'(cr8), 4);
      chk("sim_pre_lcrdv", 128'(if8.rx_lcrdv), 1);
      if8.deq_ready = 1'b1;
      if8.rx_flitv = 1'b1; if8.rx_flit = mk(32'h3001); if8.rx_flitpend = 1'b0;
      tick();
      if8.deq_ready = 1'b0; if8.rx_flitv = 1'b0;
      chk("sim_occ_same", 128'(occ8), 3);
      chk("sim_cr_same",  128'(cr8), 4);
      chk("sim_head0", if8.deq_data, mk(32'h2002));
      if8.deq_ready = 1'b1;
      tick();
      chk("sim_head1", if8.deq_data, mk(32'h3000));
      tick();
      chk("sim_head2", if8.deq_data, mk(32'h3001));
      tick();
      if8.deq_ready = 1'b0;
      chk("sim_empty", 128'(if8.deq_valid), 0);

      // ---------------- d4 link-up ----------------
      snap = n_lcrd4;
      link4 = 1'b1;
      tick(8);
      chk("d4_lcrd_count", 128'(n_lcrd4 - snap), 4);
      chk("d4_cred", 128'(cr4), 4);

      // flitv without pend one cycle earlier is ignored
      if4.rx_flitv = 1'b1; if4.rx_flit = mk(32'h4999);
      tick();
      if4.rx_flitv = 1'b0;
      chk("nopend_occ",  128'(occ4), 0);
      chk("nopend_cred", 128'(cr4), 4);

      // ---------------- d4 throughput ----------------
      if4.rx_flitpend = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         if4.rx_flitv = 1'b1; if4.rx_flit = mk(32'h4000 + 32'(i)); if4.rx_flitpend = (i < 3);
         tick();
      end
      if4.rx_flitv = 1'b0;
      chk("thr_occ",  128'(occ4), 4);
      chk("thr_cred", 128'(cr4), 0);
      chk("thr_head", if4.deq_data, mk(32'h4000));
      snap = n_lcrd4;
      tick(5);
      chk("thr_no_lcrd", 128'(n_lcrd4 - snap), 0);
      snap = n_lcrd4;
      if4.deq_ready = 1'b1;
      tick();
      if4.deq_ready = 1'b0;
      chk("pop_lcrdv_n1", 128'(if4.rx_lcrdv), 0);
      chk("pop_occ",      128'(occ4), 3);
      chk("pop_head",     if4.deq_data, mk(32'h4001));
      tick();
      chk("pop_lcrdv_n2", 128'(if4.rx_lcrdv), 1);
      tick();
      chk("pop_lcrdv_n3", 128'(if4.rx_lcrdv), 0);
      chk("pop_cred",     128'(cr4), 1);
      tick(3);
      chk("pop_one_lcrd", 128'(n_lcrd4 - snap), 1);

      // ---------------- d4 no-credit flit ----------------
      if4.rx_flitpend = 1'b1;
      tick();
      if4.rx_flitv = 1'b1; if4.rx_flit = mk(32'h4004);
      tick();
      chk("nc_pre_occ", 128'(occ4), 4);
      chk("nc_pre_cr",  128'(cr4), 0);
      chk("nc_pre_err", 128'(en4), 0);
      if4.rx_flitv = 1'b1; if4.rx_flit = mk(32'h4005); if4.rx_flitpend = 1'b0;
      tick();
      if4.rx_flitv = 1'b0;
      chk("nc_occ",  128'(occ4), 4);
      chk("nc_cr",   128'(cr4), 0);
      chk("nc_err",  128'(en4), 1);
      tick(3);
      chk("nc_err_sticky", 128'(en4), 1);
      chk("nc_occ_hold",   128'(occ4), 4);

      // ---------------- d4 deactivation ----------------
      if4.deq_ready = 1'b1;
      tick(2);
      if4.deq_ready = 1'b0;
      chk("dea_head", if4.deq_data, mk(32'h4003));
      tick(6);
      chk("dea_cr2",  128'(cr4), 2);
      chk("dea_occ2", 128'(occ4), 2);
      snap = n_lcrd4;
      link4 = 1'b0;
      tick();
      chk("dea_ack_hold", 128'(ack4), 1);
      if4.rx_flitpend = 1'b1;
      tick();
      if4.rx_flitv = 1'b1; if4.rx_flit = mk(32'h5000);
      tick();
      if4.rx_flitv = 1'b1; if4.rx_flit = mk(32'h5001); if4.rx_flitpend = 1'b0;
      tick();
      if4.rx_flitv = 1'b0;
      chk("dea_cr0",      128'(cr4), 0);
      chk("dea_ack_last", 128'(ack4), 1);
      chk("dea_occ4",     128'(occ4), 4);
      tick();
      chk("dea_ack_fall", 128'(ack4), 0);
      tick(3);
      chk("dea_no_lcrd",  128'(n_lcrd4 - snap), 0);
      if4.deq_ready = 1'b1;
      chk("dea_q0", if4.deq_data, mk(32'h4003));
      tick();
      chk("dea_q1", if4.deq_data, mk(32'h4004));
      tick();
      chk("dea_q2", if4.deq_data, mk(32'h5000));
      tick();
      chk("dea_q3", if4.deq_data, mk(32'h5001));
      tick();
      if4.deq_ready = 1'b0;
      chk("dea_empty", 128'(if4.deq_valid), 0);
      chk("dea_err_sticky", 128'(en4), 1);

      // ---------------- reset mid-operation ----------------
      rst_n = 1'b0;
      #2;
      chk("rst2_err",  128'(en4), 0);
      chk("rst2_cr8",  128'(cr8), 0);
      chk("rst2_ack8", 128'(ack8), 0);
      chk("rst2_occ4", 128'(occ4), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
